// File: rtl/myhardware_multi_timer.sv
// Multi-channel Avalon-MM interval timer with per-channel IRQ and PWM.
// Each channel is an independent down-counter with one-shot/continuous mode.
module myhardware_multi_timer #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 49999,
  parameter int ADDR_W       = $clog2(NUM_CH) + 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam logic [CNT_W-1:0] RST_P = CNT_W'(RESET_PERIOD);

  logic              w_wr;
  logic [ADDR_W-1:0] w_chn;
  logic [2:0]        w_off;
  logic [31:0]       w_rd [NUM_CH];
  logic [31:0]       w_rdsel;

  assign w_wr  = chipselect && !write_n;
  assign w_chn = address >> 3;
  assign w_off = address[2:0];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_per;
    logic [CNT_W-1:0] r_cmp;
    logic             r_ito;
    logic             r_cont;
    logic             r_pwmen;
    logic             r_to;
    logic             r_run;
    logic             r_frl;
    logic             r_pwm;
    logic             w_sel;
    logic             w_wr_st;
    logic             w_wr_ct;
    logic             w_wr_pe;
    logic             w_wr_cm;
    logic             w_start;
    logic             w_stop;
    logic             w_tev;

    assign w_sel   = w_wr && (w_chn == ADDR_W'(c));
    assign w_wr_st = w_sel && (w_off == 3'd0);
    assign w_wr_ct = w_sel && (w_off == 3'd1);
    assign w_wr_pe = w_sel && (w_off == 3'd2);
    assign w_wr_cm = w_sel && (w_off == 3'd3);
    assign w_start = w_wr_ct && writedata[2];
    assign w_stop  = w_wr_ct && writedata[3];
    assign w_tev   = r_run && (r_cnt == '0);

    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt   <= RST_P;
        r_per   <= RST_P;
        r_cmp   <= '0;
        r_ito   <= 1'b0;
        r_cont  <= 1'b0;
        r_pwmen <= 1'b0;
        r_to    <= 1'b0;
        r_run   <= 1'b0;
        r_frl   <= 1'b0;
        r_pwm   <= 1'b0;
      end else begin
        if (w_wr_pe) r_per <= writedata[CNT_W-1:0];
        if (w_wr_cm) r_cmp <= writedata[CNT_W-1:0];
        if (w_wr_ct) begin
          r_ito   <= writedata[0];
          r_cont  <= writedata[1];
          r_pwmen <= writedata[4];
        end
        r_frl <= w_wr_pe;
        if (r_run || r_frl) begin
          if (r_cnt == '0 || r_frl) r_cnt <= r_per;
          else r_cnt <= r_cnt - CNT_W'(1);
        end
        // START beats every clearing source, including a same-cycle STOP
        if (w_start) r_run <= 1'b1;
        else if (w_stop || r_frl || (w_tev && !r_cont)) r_run <= 1'b0;
        // a timeout outranks a software clear so no interrupt is lost
        if (w_tev) r_to <= 1'b1;
        else if (w_wr_st) r_to <= 1'b0;
        r_pwm <= r_run && r_pwmen && (r_cnt < r_cmp);
      end
    end

    always_comb begin
      w_rd[c] = '0;
      case (w_off)
        3'd0:    w_rd[c] = {30'd0, r_run, r_to};
        3'd1:    w_rd[c] = {27'd0, r_pwmen, 2'b00, r_cont, r_ito};
        3'd2:    w_rd[c] = 32'(r_per);
        3'd3:    w_rd[c] = 32'(r_cmp);
        3'd4:    w_rd[c] = 32'(r_cnt);
        default: w_rd[c] = '0;
      endcase
    end

    assign irq_vec[c] = r_to && r_ito;
    assign pwm_out[c] = r_pwm;
  end

  always_comb begin
    w_rdsel = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (w_chn == ADDR_W'(c)) w_rdsel = w_rd[c];
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else readdata <= w_rdsel;
  end

  assign irq = |irq_vec;

endmodule

// File: tb/tb_myhardware_multi_timer.sv
// Directed bench for myhardware_multi_timer: 4 channels, 16-bit counters.
// Extra address bit lets channel indices 4..7 be probed.
module tb_myhardware_multi_timer;

  localparam int NCH = 4;
  localparam int AW  = 6;

  logic           clk = 1'b0;
  logic           reset;
  logic [AW-1:0]  address;
  logic           chipselect;
  logic           write_n;
  logic [31:0]    writedata;
  logic [31:0]    readdata;
  logic           irq;
  logic [NCH-1:0] irq_vec;
  logic [NCH-1:0] pwm_out;

  int n_cmp = 0;
  int n_err = 0;

  myhardware_multi_timer #(
    .NUM_CH(NCH), .CNT_W(16), .RESET_PERIOD(49999), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata),
    .irq(irq), .irq_vec(irq_vec), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] a(input int ch, input int off);
    return AW'(ch * 8 + off);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] ad, input logic [31:0] d);
    address = ad; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [AW-1:0] ad, output logic [31:0] d);
    address = ad; chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk);
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int cyc;
    int hi;

    reset = 1'b1; address = '0; chipselect = 1'b0;
    write_n = 1'b1; writedata = '0;
    tick(3);
    reset = 1'b0;
    chk("rst_readdata", readdata, 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_irq_vec", 32'(irq_vec), 0);
    chk("rst_pwm", 32'(pwm_out), 0);
    rd(a(0, 0), d); chk("rst_status", d, 0);
    rd(a(0, 1), d); chk("rst_control", d, 0);
    rd(a(0, 2), d); chk("rst_period", d, 49999);
    rd(a(0, 3), d); chk("rst_compare", d, 0);
    rd(a(0, 4), d); chk("rst_count", d, 49999);

    // ch1 continuous with interrupt, period 9
    wr(a(1, 2), 9);
    wr(a(1, 1), 32'h3);
    wr(a(1, 1), 32'h7);
    cyc = 0;
    while (irq_vec[1] !== 1'b1 && cyc < 40) begin tick(1); cyc++; end
    chk("ch1_first_to_cycles", cyc, 10);
    chk("ch1_irq", 32'(irq), 1);
    wr(a(1, 0), 0);
    chk("ch1_irq_cleared", 32'(irq_vec[1]), 0);
    rd(a(1, 0), d); chk("ch1_run_kept", d, 2);
    cyc = 0;
    while (irq_vec[1] !== 1'b1 && cyc < 40) begin tick(1); cyc++; end
    chk("ch1_second_to_cycles", cyc, 8);
    wr(a(1, 0), 0);
    tick(8);
    wr(a(1, 0), 0);
    chk("ch1_clear_on_timeout", 32'(irq_vec[1]), 1);
    rd(a(1, 0), d); chk("ch1_status_to_run", d, 3);
    wr(a(1, 1), 32'hB);
    wr(a(1, 0), 0);
    rd(a(1, 0), d); chk("ch1_stopped", d, 0);
    chk("ch1_irq_low", 32'(irq), 0);

    // ch0 one-shot, period 4
    wr(a(0, 2), 4);
    wr(a(0, 1), 32'h5);
    cyc = 0;
    while (irq_vec[0] !== 1'b1 && cyc < 40) begin tick(1); cyc++; end
    chk("ch0_oneshot_cycles", cyc, 5);
    rd(a(0, 0), d); chk("ch0_run_cleared", d, 1);
    wr(a(0, 0), 0);
    tick(20);
    chk("ch0_single_to", 32'(irq_vec[0]), 0);
    rd(a(0, 4), d); chk("ch0_count_hold_a", d, 4);
    tick(5);
    rd(a(0, 4), d); chk("ch0_count_hold_b", d, 4);

    // ch2 PWM, period 9, compare 3
    wr(a(2, 2), 9);
    wr(a(2, 3), 3);
    wr(a(2, 1), 32'h12);
    wr(a(2, 1), 32'h16);
    tick(1);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (pwm_out[2]) hi++;
      tick(1);
    end
    chk("ch2_pwm_duty", hi, 6);
    cyc = 0;
    while (pwm_out[2] !== 1'b0 && cyc < 30) begin tick(1); cyc++; end
    while (pwm_out[2] !== 1'b1 && cyc < 30) begin tick(1); cyc++; end
    chk("ch2_pwm_rise_seen", 32'(cyc < 30), 1);
    wr(a(2, 1), 32'h1A);
    chk("ch2_pwm_before_stop", 32'(pwm_out[2]), 1);
    tick(1);
    chk("ch2_pwm_after_stop", 32'(pwm_out[2]), 0);
    tick(12);
    chk("ch2_pwm_stays_low", 32'(pwm_out[2]), 0);

    // ch3: START+STOP together, then PERIOD write while running
    wr(a(3, 1), 32'hC);
    rd(a(3, 0), d); chk("ch3_start_wins", d, 2);
    tick(3);
    wr(a(3, 2), 100);
    tick(1);
    rd(a(3, 0), d); chk("ch3_period_stops", d, 0);
    rd(a(3, 4), d); chk("ch3_count_new_period", d, 100);
    rd(a(3, 4), d); chk("ch3_count_held", d, 100);

    // unmapped offsets and channels
    wr(a(0, 5), 32'hFFFF_FFFF);
    rd(a(0, 5), d); chk("off5_reads_zero", d, 0);
    wr(a(5, 2), 32'h55);
    rd(a(1, 2), d); chk("ch5_no_alias", d, 9);
    rd(a(5, 2), d); chk("ch5_reads_zero", d, 0);
    rd(a(7, 4), d); chk("ch7_reads_zero", d, 0);

    // reset in the middle of activity on every channel
    wr(a(0, 1), 32'h17);
    wr(a(1, 1), 32'h7);
    wr(a(2, 1), 32'h16);
    wr(a(3, 1), 32'h4);
    tick(7);
    chk("pre_reset_irq", 32'(irq), 1);
    address = a(0, 2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mid_rst_readdata", readdata, 0);
    chk("mid_rst_irq", 32'(irq), 0);
    chk("mid_rst_irq_vec", 32'(irq_vec), 0);
    chk("mid_rst_pwm", 32'(pwm_out), 0);
    for (int ch = 0; ch < NCH; ch++) begin
      for (int off = 0; off < 5; off++) begin
        rd(a(ch, off), d);
        chk($sformatf("mid_rst_ch%0d_off%0d", ch, off), d,
            (off == 2 || off == 4) ? 32'd49999 : 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
